// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor built from 2-bit saturating counters indexed by PC[INDEX_BITS+1:2]
//   CLK, RESET_N (async, active-low)   clock and reset
//   CLEAR / BUSY                       start or restart the table clear sweep / sweep in progress
//   PRED_EN, PRED_PC                   fetch-side lookup request
//   PRED_VALID, PRED_TAKEN             registered prediction, one cycle after PRED_EN
//   UPD_EN, UPD_OPCODE_6_TO_2,         execute-side resolved branch write-back
//   UPD_PC, UPD_TAKEN
//   Define BRANCH_PREDICTOR_BYPASS_EN to forward a same-cycle, same-index update onto the prediction.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CLEAR,
  output logic        BUSY,
  input  logic        PRED_EN,
  input  logic [31:0] PRED_PC,
  output logic        PRED_VALID,
  output logic        PRED_TAKEN,
  input  logic        UPD_EN,
  input  logic [4:0]  UPD_OPCODE_6_TO_2,
  input  logic [31:0] UPD_PC,
  input  logic        UPD_TAKEN
);
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  typedef enum logic {CLEARING, READY} state_t;
  state_t state, state_nxt;
  logic [INDEX_BITS-1:0] ptr, ptr_nxt, pred_idx, upd_idx;
  logic [1:0] mem [2**INDEX_BITS];
  logic [1:0] upd_cur, upd_new;
  logic upd_hit, pred_bit, unused;
  assign pred_idx = PRED_PC[INDEX_BITS+1:2];
  assign upd_idx = UPD_PC[INDEX_BITS+1:2];
  assign unused = ^{PRED_PC[31:INDEX_BITS+2], PRED_PC[1:0], UPD_PC[31:INDEX_BITS+2], UPD_PC[1:0]};
  assign upd_cur = mem[upd_idx];
  assign upd_new = UPD_TAKEN ? ((upd_cur == 2'b11) ? 2'b11 : upd_cur + 2'd1)
                             : ((upd_cur == 2'b00) ? 2'b00 : upd_cur - 2'd1);
  // An accepted CLEAR in READY swallows that cycle's update.
  assign upd_hit = UPD_EN && UPD_OPCODE_6_TO_2 == OPCODE_BRANCH && state == READY && !CLEAR;
`ifdef BRANCH_PREDICTOR_BYPASS_EN
  assign pred_bit = (upd_hit && upd_idx == pred_idx) ? upd_new[1] : mem[pred_idx][1];
`else
  assign pred_bit = mem[pred_idx][1];
`endif
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= CLEARING;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
    end
  end
  always_comb begin
    state_nxt = (CLEAR || (state == CLEARING && !(&ptr))) ? CLEARING : READY;
    ptr_nxt = CLEAR ? '0 : (state == CLEARING) ? ptr + INDEX_BITS'(1) : ptr;
  end
  always_comb BUSY = (state == CLEARING);
  // Table has no reset; the sweep initialises it one entry per cycle.
  always_ff @(posedge CLK) begin
    if (state == CLEARING) mem[ptr] <= INIT_STATE;
    else if (upd_hit) mem[upd_idx] <= upd_new;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PRED_VALID <= 1'b0;
      PRED_TAKEN <= 1'b0;
    end else begin
      PRED_VALID <= PRED_EN;
      if (PRED_EN) PRED_TAKEN <= (state == CLEARING || CLEAR) ? 1'b0 : pred_bit;
    end
  end
endmodule
